// File: rtl/ram_dma_pkg.sv
// Shared constants for the RAM-to-RAM copy engine: default widths and FSM encodings.
package ram_dma_pkg;

  localparam int unsigned DatWidthDef = 32;
  localparam int unsigned AdrWidthDef = 32;

  localparam logic [1:0] StIdleEnc  = 2'd0;
  localparam logic [1:0] StRunEnc   = 2'd1;
  localparam logic [1:0] StDrainEnc = 2'd2;
  localparam logic [1:0] StDoneEnc  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = StIdleEnc,
    StRun   = StRunEnc,
    StDrain = StDrainEnc,
    StDone  = StDoneEnc
  } dma_state_e;

endpackage

// File: rtl/ram_copy_dma_if.sv
// Dual-port RAM bus seen by the copy engine: port 0 reads, port 1 writes.
interface ram_copy_dma_if
  import ram_dma_pkg::*;
#(
  parameter int unsigned dat_width = DatWidthDef,
  parameter int unsigned adr_width = AdrWidthDef
);

  logic [adr_width-1:0] adr0_o;
  logic                 we0_o;
  logic [dat_width-1:0] dat0_i;
  logic [adr_width-1:0] adr1_o;
  logic [dat_width-1:0] dat1_o;
  logic                 we1_o;

  // Copy engine side.
  modport master (
    output adr0_o,
    output we0_o,
    input  dat0_i,
    output adr1_o,
    output dat1_o,
    output we1_o
  );

  // RAM side.
  modport slave (
    input  adr0_o,
    input  we0_o,
    output dat0_i,
    input  adr1_o,
    input  dat1_o,
    input  we1_o
  );

endinterface

// File: rtl/ram_copy_dma.sv
// Word-by-word RAM copy engine: one read issued per cycle on port 0, the matching write
// follows one cycle later on port 1 using the RAM's registered read data.
module ram_copy_dma
  import ram_dma_pkg::*;
#(
  parameter int unsigned dat_width = DatWidthDef,
  parameter int unsigned adr_width = AdrWidthDef
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [adr_width-1:0] src_i,
  input  logic [adr_width-1:0] dst_i,
  input  logic [adr_width-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic [adr_width-1:0] count_o,
  output logic [dat_width-1:0] csum_o,
  ram_copy_dma_if.master       ram
);

  localparam logic [adr_width-1:0] AdrOne = adr_width'(1);

  dma_state_e           state_q, state_d;
  logic [adr_width-1:0] rd_adr_q, rd_adr_d;
  logic [adr_width-1:0] wr_adr_q, wr_adr_d;
  logic [adr_width-1:0] rem_q, rem_d;     // reads still to issue, including this cycle's
  logic                 rd_vld_q, rd_vld_d; // a read was issued last cycle, its write is due now
  logic                 aborted_q, aborted_d;
  logic [adr_width-1:0] count_q, count_d;
  logic [dat_width-1:0] csum_q, csum_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_adr_q  <= '0;
      wr_adr_q  <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      aborted_q <= 1'b0;
      count_q   <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_adr_q  <= rd_adr_d;
      wr_adr_q  <= wr_adr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= rd_vld_d;
      aborted_q <= aborted_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
    end
  end

  // Next-state logic: write-side bookkeeping first, then FSM transitions.
  always_comb begin
    state_d   = state_q;
    rd_adr_d  = rd_adr_q;
    wr_adr_d  = wr_adr_q;
    rem_d     = rem_q;
    rd_vld_d  = 1'b0;
    aborted_d = aborted_q;
    count_d   = count_q;
    csum_d    = csum_q;

    if (rd_vld_q) begin
      wr_adr_d = wr_adr_q + AdrOne;
      count_d  = count_q + AdrOne;
      csum_d   = csum_q + ram.dat0_i;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d   = '0;
          csum_d    = '0;
          aborted_d = 1'b0;
          if (len_i != '0) begin
            rd_adr_d = src_i;
            wr_adr_d = dst_i;
            rem_d    = len_i;
            state_d  = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        // The read presented this cycle always counts, even when abort arrives with it.
        rd_vld_d = 1'b1;
        rd_adr_d = rd_adr_q + AdrOne;
        rem_d    = rem_q - AdrOne;
        if (rem_q == AdrOne) begin
          state_d = StDrain;
        end else if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status and RAM port outputs.
  always_comb begin
    busy_o     = (state_q == StRun) || (state_q == StDrain);
    done_o     = (state_q == StDone);
    aborted_o  = aborted_q;
    count_o    = count_q;
    csum_o     = csum_q;
    ram.adr0_o = rd_adr_q;
    ram.we0_o  = 1'b0;
    ram.adr1_o = wr_adr_q;
    ram.dat1_o = rd_vld_q ? ram.dat0_i : '0;
    ram.we1_o  = rd_vld_q;
  end

endmodule

// File: tb/tb_ram_copy_dma.sv
// Scoreboard bench for ram_copy_dma paired with a read-before-write dual-port RAM model.
module tb_ram_copy_dma;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  typedef struct {
    int            lat;
    logic [AW-1:0] cnt;
    logic [DW-1:0] csum;
    logic          ab;
  } dn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] src_i = '0;
  logic [AW-1:0] dst_i = '0;
  logic [AW-1:0] len_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, aborted_o;
  logic [AW-1:0] count_o;
  logic [DW-1:0] csum_o;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_rd = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_adr = '0;
  logic [DW-1:0] pl_dat = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_seen = 0;
  wr_t wr_q[$];
  dn_t dn_q[$];

  ram_copy_dma_if #(.dat_width(DW), .adr_width(AW)) bus ();

  ram_copy_dma #(.dat_width(DW), .adr_width(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .src_i     (src_i),
    .dst_i     (dst_i),
    .len_i     (len_i),
    .abort_i   (abort_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .aborted_o (aborted_o),
    .count_o   (count_o),
    .csum_o    (csum_o),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: the read returns the value before a same-cycle write.
  always @(posedge clk) begin
    ram_rd <= mem[bus.adr0_o];
    if (bus.we1_o) mem[bus.adr1_o] <= bus.dat1_o;
    if (pl_en) mem[pl_adr] <= pl_dat;
  end
  assign bus.dat0_i = ram_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    wr_q.push_back(w);
  endtask

  task automatic push_dn(input int lat, input logic [AW-1:0] c, input logic [DW-1:0] s,
                         input logic ab);
    dn_t e;
    e.lat = lat;
    e.cnt = c;
    e.csum = s;
    e.ab = ab;
    dn_q.push_back(e);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_adr = a;
    pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one start; abort_at>0 raises abort_i during that RUN cycle (1-based).
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, input int abort_at);
    int n0;
    n0 = done_seen;
    @(negedge clk);
    start_i = 1'b1;
    src_i = s;
    dst_i = d;
    len_i = n;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
    end
    for (int i = 0; i < 64 && done_seen == n0; i++) @(posedge clk);
    if (done_seen == n0) begin
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done_o within 64 cycles");
    end
  endtask

  // Monitor: compares every write and every completion against the scoreboard.
  initial begin
    wr_t w;
    dn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.we1_o) begin
          check("busy_during_write", busy_o, 1);
          if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=adr 0x%0h expected=no write", bus.adr1_o);
          end else begin
            w = wr_q.pop_front();
            check("wr_adr", bus.adr1_o, w.adr);
            check("wr_dat", bus.dat1_o, w.dat);
          end
        end
        if (done_o) begin
          done_seen++;
          check("busy_at_done", busy_o, 0);
          check("we1_at_done", bus.we1_o, 0);
          if (dn_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done_o expected=no done");
          end else begin
            e = dn_q.pop_front();
            check("done_latency", cyc - start_cyc, e.lat);
            check("count", count_o, e.cnt);
            check("csum", csum_o, e.csum);
            check("aborted", aborted_o, e.ab);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_aborted"}, aborted_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_csum"}, csum_o, 0);
    check({tag, "_adr0"}, bus.adr0_o, 0);
    check({tag, "_adr1"}, bus.adr1_o, 0);
    check({tag, "_dat1"}, bus.dat1_o, 0);
    check({tag, "_we1"}, bus.we1_o, 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    check("we0_tied", bus.we0_o, 0);
    preload(8'h10, 32'd1);
    preload(8'h11, 32'd2);
    preload(8'h12, 32'd3);
    preload(8'h13, 32'd4);
    preload(8'h14, 32'd5);
    preload(8'h15, 32'd6);
    preload(8'h16, 32'd7);
    preload(8'h17, 32'd8);
    preload(8'h20, 32'h8000_0001);
    preload(8'h21, 32'h8000_0002);
    preload(8'h22, 32'h0000_0003);
    preload(8'h23, 32'h0000_0099);
    preload(8'h63, 32'h0000_dead);
    preload(8'h72, 32'h0000_beef);
    preload(8'hff, 32'h11);
    preload(8'h00, 32'h22);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 4-word copy.
    for (int k = 0; k < 4; k++) push_wr(8'h40 + 8'(k), 32'(k + 1));
    push_dn(6, 8'd4, 32'd10, 1'b0);
    run_copy(8'h10, 8'h40, 8'd4, 0);
    for (int k = 0; k < 4; k++) check("mem_basic", mem[8'h40 + 8'(k)], 32'(k + 1));

    // Zero length: immediate done, counters cleared, no writes.
    push_dn(1, 8'd0, 32'd0, 1'b0);
    run_copy(8'h10, 8'h50, 8'd0, 0);

    // Abort in the 3rd RUN cycle of an 8-word copy.
    push_wr(8'h60, 32'd1);
    push_wr(8'h61, 32'd2);
    push_wr(8'h62, 32'd3);
    push_dn(5, 8'd3, 32'd6, 1'b1);
    run_copy(8'h10, 8'h60, 8'd8, 3);
    check("abort_no_extra_write", mem[8'h63], 32'h0000_dead);

    // Abort coinciding with the last read counts as complete.
    push_wr(8'h68, 32'd1);
    push_wr(8'h69, 32'd2);
    push_dn(4, 8'd2, 32'd3, 1'b0);
    run_copy(8'h10, 8'h68, 8'd2, 2);

    // Abort during DRAIN is ignored.
    push_wr(8'h6c, 32'd1);
    push_dn(3, 8'd1, 32'd1, 1'b0);
    run_copy(8'h10, 8'h6c, 8'd1, 2);

    // Overlap dst == src+1 copies the original data; checksum wraps modulo 2^32.
    push_wr(8'h21, 32'h8000_0001);
    push_wr(8'h22, 32'h8000_0002);
    push_wr(8'h23, 32'h0000_0003);
    push_dn(5, 8'd3, 32'h0000_0006, 1'b0);
    run_copy(8'h20, 8'h21, 8'd3, 0);
    check("mem_ovl_21", mem[8'h21], 32'h8000_0001);
    check("mem_ovl_22", mem[8'h22], 32'h8000_0002);
    check("mem_ovl_23", mem[8'h23], 32'h0000_0003);

    // Source address wraps from the top of memory to 0.
    push_wr(8'h80, 32'h11);
    push_wr(8'h81, 32'h22);
    push_dn(4, 8'd2, 32'h33, 1'b0);
    run_copy(8'hff, 8'h80, 8'd2, 0);

    // Reset mid-RUN: two writes land, then everything clears and no further writes occur.
    push_wr(8'h70, 32'd1);
    push_wr(8'h71, 32'd2);
    @(negedge clk);
    start_i = 1'b1;
    src_i = 8'h10;
    dst_i = 8'h70;
    len_i = 8'd8;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_write", mem[8'h72], 32'h0000_beef);
    check("midrst_wr_consumed", wr_q.size(), 0);

    // A fresh copy after the reset completes normally.
    for (int k = 0; k < 4; k++) push_wr(8'h48 + 8'(k), 32'(k + 5));
    push_dn(6, 8'd4, 32'd26, 1'b0);
    run_copy(8'h14, 8'h48, 8'd4, 0);

    repeat (3) @(negedge clk);
    check("wr_leftover", wr_q.size(), 0);
    check("done_leftover", dn_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
